// File: rtl/pool_tile_fetch_pkg.sv
// Shared constants and types for the pooling tile fetcher.
// Build option: BRAM_OREG_EN selects a BRAM with an output register (read latency 2).
package pool_tile_fetch_pkg;

    localparam int TILE_PIX   = 4;
    localparam int PIX_W      = 8;
    localparam int TILE_BITS  = 128;
    localparam int TILE_ELEMS = TILE_PIX * TILE_PIX;

`ifdef BRAM_OREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        PRESENT,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/pool_tile_addr_gen.sv
// Tile/element walk counters for the tile fetcher: raster order over tiles,
// row-major over the 16 pixels of a tile, producing the wrapped BRAM address.
module pool_tile_addr_gen
    import pool_tile_fetch_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int STRIDE = 2,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_in,
    input  logic              elem_step,
    input  logic              tile_step,
    output logic [ADDR_W-1:0] addr,
    output logic [3:0]        elem,
    output logic              last_elem,
    output logic              last_tile,
    output logic [7:0]        tile_row,
    output logic [7:0]        tile_col
);

    localparam int TW = (IMG_W - TILE_PIX) / STRIDE + 1;
    localparam int TH = (IMG_H - TILE_PIX) / STRIDE + 1;

    logic [ADDR_W-1:0] base_reg;
    logic [7:0]        tr_reg;
    logic [7:0]        tc_reg;
    logic [1:0]        r_reg;
    logic [1:0]        c_reg;
    logic [31:0]       row_idx;
    logic [31:0]       col_idx;

    // Counter update: load restarts the walk; elements and tiles advance independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_reg <= '0;
            tr_reg   <= '0;
            tc_reg   <= '0;
            r_reg    <= '0;
            c_reg    <= '0;
        end else if (load) begin
            base_reg <= base_in;
            tr_reg   <= '0;
            tc_reg   <= '0;
            r_reg    <= '0;
            c_reg    <= '0;
        end else begin
            if (elem_step) begin
                c_reg <= c_reg + 2'd1;
                if (c_reg == 2'd3) begin
                    r_reg <= r_reg + 2'd1;
                end
            end
            if (tile_step) begin
                if (last_tile) begin
                    tr_reg <= '0;
                    tc_reg <= '0;
                end else if (tc_reg == 8'(TW - 1)) begin
                    tc_reg <= '0;
                    tr_reg <= tr_reg + 8'd1;
                end else begin
                    tc_reg <= tc_reg + 8'd1;
                end
            end
        end
    end

    // Address is computed modulo 2^ADDR_W; truncating each term first is equivalent.
    always_comb begin
        row_idx = {24'd0, tr_reg} * STRIDE + {30'd0, r_reg};
        col_idx = {24'd0, tc_reg} * STRIDE + {30'd0, c_reg};
        addr    = base_reg + ADDR_W'(row_idx * IMG_W) + ADDR_W'(col_idx);
    end

    assign elem      = {r_reg, c_reg};
    assign last_elem = (r_reg == 2'd3) && (c_reg == 2'd3);
    assign last_tile = (tr_reg == 8'(TH - 1)) && (tc_reg == 8'(TW - 1));
    assign tile_row  = tr_reg;
    assign tile_col  = tc_reg;

endmodule

// File: rtl/pool_tile_fetch.sv
// Fetches 4x4 pixel tiles from a byte-wide feature-map BRAM and presents them
// as a packed 128-bit tile with a valid/ready handshake.
// Build option: BRAM_OREG_EN (read latency 2 instead of 1).
module pool_tile_fetch
    import pool_tile_fetch_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int STRIDE = 2,
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 bram_en,
    output logic [ADDR_W-1:0]    bram_addr,
    input  logic [7:0]           bram_dout,
    output logic                 tile_valid,
    input  logic                 tile_ready,
    output logic [TILE_BITS-1:0] tile_data,
    output logic [7:0]           tile_row,
    output logic [7:0]           tile_col
);

    fetch_state_t state_reg;
    fetch_state_t state_next;

    logic                 load;
    logic                 elem_step;
    logic                 tile_step;
    logic [ADDR_W-1:0]    gen_addr;
    logic [3:0]           gen_elem;
    logic                 last_elem;
    logic                 last_tile;
    logic [1:0]           drain_cnt_reg;
    logic [TILE_BITS-1:0] tile_data_reg;
    logic                 cap_vld;
    logic [3:0]           cap_elem;

    pool_tile_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .STRIDE (STRIDE),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .base_in   (base_addr),
        .elem_step (elem_step),
        .tile_step (tile_step),
        .addr      (gen_addr),
        .elem      (gen_elem),
        .last_elem (last_elem),
        .last_tile (last_tile),
        .tile_row  (tile_row),
        .tile_col  (tile_col)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and Moore outputs; ready only matters while presenting.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        elem_step  = 1'b0;
        tile_step  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        tile_valid = 1'b0;
        bram_en    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                busy      = 1'b1;
                bram_en   = 1'b1;
                elem_step = 1'b1;
                if (last_elem) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt_reg == 2'(RD_LAT - 1)) begin
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                busy       = 1'b1;
                tile_valid = 1'b1;
                if (tile_ready) begin
                    tile_step  = 1'b1;
                    state_next = last_tile ? DONE : ISSUE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counts cycles spent waiting for the final reads to return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt_reg <= '0;
        end else if (state_reg == DRAIN) begin
            drain_cnt_reg <= drain_cnt_reg + 2'd1;
        end else begin
            drain_cnt_reg <= '0;
        end
    end

    // Delay line carrying each read's element index alongside its BRAM latency.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_rd_pipe
            logic       vld_in;
            logic [3:0] elem_in;
            logic       vld_reg;
            logic [3:0] elem_reg;

            if (gi == 0) begin : g_head
                assign vld_in  = bram_en;
                assign elem_in = gen_elem;
            end else begin : g_tail
                assign vld_in  = g_rd_pipe[gi-1].vld_reg;
                assign elem_in = g_rd_pipe[gi-1].elem_reg;
            end

            // One stage of the read-return tracking pipeline.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_reg  <= 1'b0;
                    elem_reg <= '0;
                end else begin
                    vld_reg  <= vld_in;
                    elem_reg <= elem_in;
                end
            end
        end
    endgenerate

    assign cap_vld  = g_rd_pipe[RD_LAT-1].vld_reg;
    assign cap_elem = g_rd_pipe[RD_LAT-1].elem_reg;

    // Drop returning read data into the byte lane of its element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_data_reg <= '0;
        end else if (cap_vld) begin
            tile_data_reg[{cap_elem, 3'b000} +: PIX_W] <= bram_dout;
        end
    end

    assign tile_data = tile_data_reg;
    assign bram_addr = bram_en ? gen_addr : '0;

endmodule

// File: tb/tb_pool_tile_fetch.sv
// Directed bench for pool_tile_fetch: 8x8 map, stride 2, 6-bit addresses.
module tb_pool_tile_fetch;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int STRIDE = 2;
    localparam int ADDR_W = 6;
`ifdef BRAM_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int TW     = 3;
    localparam int NT     = 9;
    localparam int FIRST  = 17 + LAT;
    localparam int PERIOD = 17 + LAT;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [5:0]    base_addr;
    logic          busy;
    logic          done;
    logic          bram_en;
    logic [5:0]    bram_addr;
    logic [7:0]    bram_dout;
    logic          tile_valid;
    logic          tile_ready;
    logic [127:0]  tile_data;
    logic [7:0]    tile_row;
    logic [7:0]    tile_col;

    logic [7:0]    mem [0:63];
    logic [7:0]    q1;
    logic [7:0]    q2;

    int            cyc = 0;
    int            base_cyc = 0;
    int            checks = 0;
    int            fails = 0;
    logic [127:0]  tile_seen [0:8];
    logic [5:0]    addr_seen [0:15];

    pool_tile_fetch #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .STRIDE (STRIDE),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .busy       (busy),
        .done       (done),
        .bram_en    (bram_en),
        .bram_addr  (bram_addr),
        .bram_dout  (bram_dout),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_data  (tile_data),
        .tile_row   (tile_row),
        .tile_col   (tile_col)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: registered read, optional output register.
    always @(posedge clk) begin
        if (bram_en) q1 <= mem[bram_addr];
        q2 <= q1;
    end
    assign bram_dout = (LAT == 2) ? q2 : q1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] pix_addr(input logic [5:0] base, input int k, input int e);
        int a;
        a = int'(base) + (STRIDE * (k / TW) + e / 4) * IMG_W + STRIDE * (k % TW) + e % 4;
        return 6'(a % 64);
    endfunction

    function automatic logic [127:0] tile_model(input logic [5:0] base, input int k);
        logic [127:0] t;
        t = '0;
        for (int e = 0; e < 16; e++) t[e*8 +: 8] = {2'b00, pix_addr(base, k, e)};
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  128'(busy), 128'(0));
        check({tag, "_done"},  128'(done), 128'(0));
        check({tag, "_en"},    128'(bram_en), 128'(0));
        check({tag, "_addr"},  128'(bram_addr), 128'(0));
        check({tag, "_valid"}, 128'(tile_valid), 128'(0));
        check({tag, "_data"},  tile_data, 128'(0));
        check({tag, "_row"},   128'(tile_row), 128'(0));
        check({tag, "_col"},   128'(tile_col), 128'(0));
    endtask

    // Runs one full map fetch with optional stall, stray start pulses, or reset abort.
    task automatic scan(input logic [5:0] base, input int stall_k, input int stall_len,
                        input bit poke, input int abort_k);
        int k = 0;
        int stall_cnt = 0;
        int n_iss = 0;
        int cyc_now;
        int exp_cyc;
        int dones = 0;
        int last_i = 0;
        bit hs_prev = 0;
        bit in_tile = 0;
        bit finished = 0;
        bit aborted = 0;
        @(negedge clk);
        base_addr = base;
        start = 1'b1;
        tile_ready = 1'b1;
        step();
        base_cyc = cyc - 1;
        start = 1'b0;
        base_addr = ~base;
        check("busy_after_start", 128'(busy), 128'(1));
        for (int i = 0; i < 400 && !finished; i++) begin
            cyc_now = cyc - base_cyc;
            if (poke) start = (cyc_now == 5);
            if (hs_prev && k < NT) check("issue_after_hs", 128'(bram_en), 128'(1));
            hs_prev = 0;
            if (bram_en) begin
                check($sformatf("addr_k%0d_e%0d", k, n_iss), 128'(bram_addr), 128'(pix_addr(base, k, n_iss)));
                if (k == 0 && n_iss < 16) addr_seen[n_iss] = bram_addr;
                n_iss++;
                if (abort_k == k && n_iss == 6) begin
                    #1 rst_n = 1'b0;
                    #1 check_all_zero("abort");
                    for (int j = 0; j < 3; j++) begin
                        step();
                        check("abort_no_done", 128'(done), 128'(0));
                    end
                    @(negedge clk);
                    rst_n = 1'b1;
                    aborted = 1;
                    finished = 1;
                end
            end
            if (!aborted && tile_valid) begin
                check("no_en_present", 128'(bram_en), 128'(0));
                check($sformatf("row_k%0d", k), 128'(tile_row), 128'(k / TW));
                check($sformatf("col_k%0d", k), 128'(tile_col), 128'(k % TW));
                check($sformatf("data_k%0d", k), tile_data, tile_model(base, k));
                if (!in_tile) begin
                    exp_cyc = FIRST + k * PERIOD + ((stall_k >= 0 && k > stall_k) ? stall_len : 0);
                    check($sformatf("valid_cycle_k%0d", k), 128'(cyc_now), 128'(exp_cyc));
                    in_tile = 1;
                end
                if (k < NT) tile_seen[k] = tile_data;
                if (k == stall_k && stall_cnt < stall_len) begin
                    tile_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    tile_ready = 1'b1;
                    check($sformatf("issued_k%0d", k), 128'(n_iss), 128'(16));
                    n_iss = 0;
                    k++;
                    hs_prev = 1;
                    in_tile = 0;
                end
            end
            if (!aborted && done) begin
                dones++;
                exp_cyc = FIRST + (NT - 1) * PERIOD + 1 + ((stall_k >= 0) ? stall_len : 0);
                check("done_cycle", 128'(cyc_now), 128'(exp_cyc));
                check("busy_at_done", 128'(busy), 128'(0));
                check("tiles_at_done", 128'(k), 128'(NT));
                if (poke) start = 1'b1;
                last_i = i;
            end else if (!aborted && dones > 0) begin
                check("idle_after_done", 128'(busy), 128'(0));
                if (i >= last_i + 4) finished = 1;
            end
            if (!finished) step();
        end
        start = 1'b0;
        if (!aborted) begin
            check("finished_in_budget", 128'(finished), 128'(1));
            check("done_count", 128'(dones), 128'(1));
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        tile_ready = 1'b1;
        repeat (3) step();
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_busy", 128'(busy), 128'(0));

        // Plain scan, base 0.
        scan(6'd0, -1, 0, 1'b0, -1);
        check("t0_px00", 128'(tile_seen[0][7:0]), 128'(8'h00));
        check("t0_px03", 128'(tile_seen[0][31:24]), 128'(8'h03));
        check("t0_px33", 128'(tile_seen[0][127:120]), 128'(8'h1B));
        check("t8_px00", 128'(tile_seen[8][7:0]), 128'(8'h24));

        // Backpressure on tile (0,1).
        scan(6'd0, 1, 10, 1'b0, -1);
        check("stall_px00", 128'(tile_seen[1][7:0]), 128'(8'h02));

        // Address wrap-around.
        scan(6'd60, -1, 0, 1'b0, -1);
        check("wrap_a0", 128'(addr_seen[0]), 128'(6'd60));
        check("wrap_a3", 128'(addr_seen[3]), 128'(6'd63));
        check("wrap_a4", 128'(addr_seen[4]), 128'(6'd4));

        // Stray start while busy and in the DONE cycle.
        scan(6'd0, -1, 0, 1'b1, -1);

        // Reset during ISSUE of tile (1,1), then a clean rerun.
        scan(6'd0, -1, 0, 1'b0, 4);
        scan(6'd0, -1, 0, 1'b0, -1);
        check("rerun_t0_px33", 128'(tile_seen[0][127:120]), 128'(8'h1B));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/pool_tile_fetch.md
# pool_tile_fetch

Reads a feature map stored one byte per address in a BRAM and assembles successive 4x4 tiles of 8-bit pixels into the packed 128-bit tile bus that the 2x2-output max-pooling stage consumes. Tiles are walked in raster order at a configurable stride and handed downstream with a valid/ready handshake. The block sits between the feature-map BRAM read port and the pooling datapath.

## Interface
- IMG_W, 8, feature-map width in pixels (>= 4)
- IMG_H, 8, feature-map height in pixels (>= 4)
- STRIDE, 2, tile step in pixels, horizontal and vertical (1..4)
- ADDR_W, 6, BRAM address width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to fetch a whole map; ignored while busy
- base_addr  in  ADDR_W  address of pixel (0,0); sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last tile handshake
- bram_en  out  1  read enable
- bram_addr  out  ADDR_W  read address
- bram_dout  in  8  read data
- tile_valid  out  1  tile_data holds a complete tile
- tile_ready  in  1  downstream accepts the tile
- tile_data  out  128  pixel (r,c) of tile at bits [(4r+c)*8 +: 8], r = row 0..3 top-down, c = column 0..3
- tile_row, tile_col  out  8 each  tile indices of the presented tile

## Operation
- Tiles per row TW = (IMG_W-4)/STRIDE+1, per column TH = (IMG_H-4)/STRIDE+1 (integer division). Tile (tr,tc) is visited in raster order.
- Pixel address = base_addr + (tr*STRIDE+r)*IMG_W + tc*STRIDE + c, truncated modulo 2^ADDR_W (wrap-around is legal).
- FSM states:
  - IDLE: start=1 latches base_addr and goes to ISSUE.
  - ISSUE: 16 reads, one per cycle, element order e=4r+c.
  - DRAIN: waits out the read latency.
  - PRESENT: tile_valid=1 until tile_ready.
  - On handshake: go to ISSUE for the next tile, or to DONE after tile (TH-1,TW-1).
  - DONE: pulses done and returns to IDLE.
- Read data is written into the byte lane of the element issued one latency earlier. The lane is selected by a delayed element index.
- tile_data, tile_row and tile_col are stable while tile_valid=1 and tile_ready=0.
- tile_ready is ignored outside PRESENT.
- start during busy has no effect; start in the DONE cycle is ignored.
- Reset values: all outputs 0 (tile_data 0, bram_addr 0), FSM in IDLE.
- Reset asserted mid-fetch aborts immediately with no done pulse.

## Timing
- Read latency L=1 (L=2 with BRAM_OREG_EN).
- Start sampled high at edge 0:
  - Element e address is driven with bram_en=1 in cycle e+1 (cycles 1..16).
  - Its data is captured at the end of cycle e+1+L.
  - tile_valid rises in cycle 17+L.
- With tile_ready held high, each tile takes 17+L cycles. The next tile's first address is issued in the cycle after the handshake.
- done pulses in the cycle after the final handshake. busy falls in that same cycle.
- No back-to-back overlap between tiles; a tile is never re-read.

## Configuration
- BRAM_OREG_EN defined: BRAM output register assumed, L=2, DRAIN lasts 2 cycles, per-tile period 19 cycles with ready high.
- BRAM_OREG_EN undefined: L=1, DRAIN lasts 1 cycle, period 18 cycles.

## Structure
- Shared package holds:
  - TILE_PIX=4
  - PIX_W=8
  - TILE_BITS=128
  - FSM state typedef (IDLE, ISSUE, DRAIN, PRESENT, DONE)
  - read-latency constant derived from BRAM_OREG_EN
- One sub-module is natural: pool_tile_addr_gen. It holds the tr/tc/r/c counters and produces the wrapped address and last-element/last-tile flags.

## Test plan
- IMG 8x8, STRIDE 2, base 0, mem[a]=a, ready high:
  - 9 tiles, tile_row/tile_col progress (0,0),(0,1),(0,2),(1,0),…,(2,2).
  - First tile: tile_data[7:0]=0x00, [31:24]=0x03, [127:120]=0x1B.
  - Tile (2,2): [7:0]=0x24.
  - done in cycle 163.
- Backpressure: hold tile_ready=0 for 10 cycles on tile (0,1) -> tile_data constant at [7:0]=0x02, no bram_en during stall, resumes issuing the cycle after ready.
- Wrap: ADDR_W=6, base_addr=60 -> first tile pixel (0,0) read from 60, pixel (0,3) from 63→wrapped to 63, pixel (1,0) from 4 (68 mod 64).
- start pulsed in cycle 5 while busy -> ignored; still exactly 9 tiles and one done.
- rst_n low during ISSUE of tile (1,1) -> all outputs 0 asynchronously, no done; a new start afterwards reproduces the first-scenario sequence.
- BRAM_OREG_EN defined, same as the first scenario -> identical tile contents, tile_valid first in cycle 19, done in cycle 172.
